// File: rtl/mul_seq_08_pkg.sv
// ==== mul_seq_08_pkg : shared types/constants for the shift-add multiplier ==== rev 1.0
`default_nettype none

package mul_seq_08_pkg;

  localparam int MUL_WIDTH = 8;
  localparam int MUL_ITERS = MUL_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, hence one bit beyond clog2.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_seq_08_if.sv
// ==== mul_seq_08_if : start/operand/result bundle of the multiplier ==== rev 1.0
`default_nettype none

interface mul_seq_08_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

`default_nettype wire

// File: rtl/mul_seq_08_dp.sv
// ==== mul_seq_08_dp : accumulator, operand register, lookahead adder and shift ==== rev 1.0
`default_nettype none

module mul_seq_08_dp
  import mul_seq_08_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_prop;
  logic [WIDTH-1:0] w_gen;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;

  assign w_addend = r_lo[0] ? r_mcand : '0;
  assign w_prop   = r_hi ^ w_addend;
  assign w_gen    = r_hi & w_addend;

  // Flattened lookahead: c[i] = OR_j ( g[j] & p[j+1..i-1] ), carry-in is zero.
  always_comb begin
    logic w_term;
    w_term  = 1'b0;
    w_carry = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      for (int j = 0; j < i; j++) begin
        w_term = w_gen[j];
        for (int k = j + 1; k < i; k++) begin
          w_term = w_term & w_prop[k];
        end
        w_carry[i] = w_carry[i] | w_term;
      end
    end
  end

  assign w_sum = w_prop ^ w_carry[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (load) begin
      r_mcand <= multiplicand;
      r_hi    <= '0;
      r_lo    <= multiplier;
    end else if (step) begin
      r_hi    <= {w_carry[WIDTH], w_sum[WIDTH-1:1]};
      r_lo    <= {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign product = {r_hi, r_lo};

endmodule

`default_nettype wire

// File: rtl/mul_seq_08.sv
// ==== mul_seq_08 : sequential unsigned shift-add multiplier, WIDTH+1 cycle latency ==== rev 1.0
`default_nettype none

module mul_seq_08
  import mul_seq_08_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  mul_seq_08_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_load;
  logic             w_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_cnt_next   = '0;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_step     = 1'b1;
        w_cnt_next = r_cnt + CNT_W'(1);
        // Leaving on this edge makes the counter land on exactly WIDTH.
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_cnt_next   = '0;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);

  mul_seq_08_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk          (clk),
    .rst          (rst),
    .load         (w_load),
    .step         (w_step),
    .multiplicand (bus.multiplicand),
    .multiplier   (bus.multiplier),
    .product      (bus.product)
  );

endmodule

`default_nettype wire
